float_div_seq: RTL and testbench

Iterative floating-point divider for the LM32 coprocessor, operating on the team's float format (sign, Ne exposant, Nm mantisse, bias 2**(Ne-1)-1).
- It is the inverse operation of the combinational multiplier. It replaces the shortreal-based divide with synthesizable RTL.
- It computes op1/op2 with a restoring mantissa division, one quotient bit per cycle.
- It uses a start/done handshake toward the coprocessor control FSM.

---
 rtl/float_pack.sv | 22 ++
 rtl/float_div_seq_mant_div_core.sv | 68 ++++++
 rtl/float_div_seq.sv | 151 +++++++++++++++
 tb/tb_float_div_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/float_pack.sv
// Shared definitions for the float format (sign, exponent, mantissa) used by
// the coprocessor arithmetic units.
package float_pack;

  localparam int NM = 23;
  localparam int NE = 8;
  localparam int FLOAT_BIAS = 2**(NE-1)-1;
  localparam int FLOAT_EXP_MAX = 2**NE-1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    SPEC = 2'd3
  } div_state_t;

  // Exponent and mantissa both zero; the sign bit does not matter.
  function automatic logic float_is_zero(input logic [NE+NM:0] f);
    return (f[NE+NM-1:0] == {(NE+NM){1'b0}});
  endfunction

endpackage

// File: rtl/float_div_seq_mant_div_core.sv
// Restoring mantissa divider: one quotient bit per step, MSB first, with the
// hidden one prepended to both operands at load.
module float_mant_div_core #(
  parameter int Nm = 23
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [Nm-1:0] m1_i,
  input  logic [Nm-1:0] m2_i,
  output logic          last_o,
  output logic [Nm+1:0] quot_o
);

  localparam int CW = $clog2(Nm+2);

  logic [Nm+1:0] rem_q, rem_d;
  logic [Nm:0]   div_q, div_d;
  logic [Nm+1:0] quot_q, quot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Nm+2:0] trial_s;
  logic [Nm+1:0] rem_sel_s;
  logic          qbit_s;

  // Trial subtraction and next-state selection for the datapath registers.
  always_comb begin
    trial_s   = {1'b0, rem_q} - {2'b00, div_q};
    qbit_s    = ~trial_s[Nm+2];
    rem_sel_s = qbit_s ? trial_s[Nm+1:0] : rem_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      rem_d  = {1'b0, 1'b1, m1_i};
      div_d  = {1'b1, m2_i};
      quot_d = {(Nm+2){1'b0}};
      cnt_d  = CW'(Nm+1);
    end else if (step_i) begin
      // The remainder stays below the divisor, so the shift never loses a bit.
      rem_d  = rem_sel_s << 1'b1;
      quot_d = {quot_q[Nm:0], qbit_s};
      cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d  = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= {(Nm+2){1'b0}};
      div_q  <= {(Nm+1){1'b0}};
      quot_q <= {(Nm+2){1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {CW{1'b0}});
  assign quot_o = quot_q;

endmodule

// File: rtl/float_div_seq.sv
// Iterative float divider: start/done handshake, exponent and sign handling,
// zero operands short-circuited, truncating normalisation.
module float_div_seq
  import float_pack::*;
#(
  parameter int Nm = NM,
  parameter int Ne = NE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Ne+Nm:0]   op1_i,
  input  logic [Ne+Nm:0]   op2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Ne+Nm:0]   result_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  localparam int W = 1 + Ne + Nm;

  div_state_t            state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  op2_zero_q, op2_zero_d;
  logic signed [Ne+1:0]  exp_tmp_q, exp_tmp_d;
  logic [W-1:0]          result_q, result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic                  load_s, step_s, last_s;
  logic [Nm+1:0]         quot_s;
  logic signed [Ne+1:0]  exp_fin_s;
  logic [Nm-1:0]         mant_s;

  float_mant_div_core #(.Nm(Nm)) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load_s),
    .step_i (step_s),
    .m1_i   (op1_i[Nm-1:0]),
    .m2_i   (op2_i[Nm-1:0]),
    .last_o (last_s),
    .quot_o (quot_s)
  );

  // Control FSM next state, exponent arithmetic and result formatting.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    op2_zero_d = op2_zero_q;
    exp_tmp_d  = exp_tmp_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    step_s     = 1'b0;
    // Quotient in [0.5,2): a clear MSB means one extra exponent decrement.
    mant_s     = quot_s[Nm+1] ? quot_s[Nm:1] : quot_s[Nm-1:0];
    exp_fin_s  = quot_s[Nm+1] ? exp_tmp_q : exp_tmp_q - $signed({{(Ne+1){1'b0}}, 1'b1});
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sign_d     = op1_i[W-1] ^ op2_i[W-1];
          op2_zero_d = float_is_zero(op2_i);
          exp_tmp_d  = $signed({2'b00, op1_i[W-2:Nm]}) - $signed({2'b00, op2_i[W-2:Nm]})
                       + $signed((Ne+2)'(FLOAT_BIAS));
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          if (float_is_zero(op1_i) || float_is_zero(op2_i)) begin
            state_d = SPEC;
          end else begin
            state_d = DIV;
            load_s  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        step_s = 1'b1;
        if (last_s) begin
          state_d = NORM;
        end else begin
          state_d = DIV;
        end
      end
      NORM: begin
        if (exp_fin_s[Ne+1] || exp_fin_s == {(Ne+2){1'b0}}) begin
          result_d = {sign_q, {(Ne+Nm){1'b0}}};
        end else if (exp_fin_s >= $signed((Ne+2)'(FLOAT_EXP_MAX))) begin
          result_d = {sign_q, {Ne{1'b1}}, {Nm{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_fin_s[Ne-1:0], mant_s};
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      SPEC: begin
        if (op2_zero_q) begin
          result_d = {sign_q, {Ne{1'b1}}, {Nm{1'b0}}};
          dbz_d    = 1'b1;
        end else begin
          result_d = {sign_q, {(Ne+Nm){1'b0}}};
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      op2_zero_q <= 1'b0;
      exp_tmp_q  <= {(Ne+2){1'b0}};
      result_q   <= {W{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      op2_zero_q <= op2_zero_d;
      exp_tmp_q  <= exp_tmp_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_float_div_seq.sv
// Scoreboard bench for float_div_seq: expected results are queued at start and
// compared when done_o pulses; latency and busy duration checked per operation.
module tb_float_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op1, op2;
  logic        busy, done, dbz, ovf;
  logic [31:0] result;

  typedef struct packed {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  float_div_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .op1_i         (op1),
    .op2_i         (op2),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result),
    .div_by_zero_o (dbz),
    .overflow_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("result", {32'd0, result}, {32'd0, e.res});
        check_eq("div_by_zero", {63'd0, dbz}, {63'd0, e.dbz});
        check_eq("overflow", {63'd0, ovf}, {63'd0, e.ovf});
      end
    end
  end

  // Issue one operation, scramble operands after accept, wait for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic e_dbz, input logic e_ovf, input int lat);
    int n;
    int busy_n;
    bit seen;
    n = 0; busy_n = 0; seen = 1'b0;
    sb_q.push_back('{res: r, dbz: e_dbz, ovf: e_ovf});
    @(negedge clk);
    op1 = a; op2 = b; start = 1'b1;
    while (n < 60 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      op1 = $urandom; op2 = $urandom;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", {63'd0, seen}, 64'd1);
    check_eq("latency", 64'(n), 64'(lat));
    check_eq("busy_cycles", 64'(busy_n), 64'(lat - 1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op1 = 32'd0; op2 = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_flags", {62'd0, dbz, ovf}, 64'd0);

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 27);
    run_op(32'hC0E00000, 32'h40000000, 32'hC0600000, 1'b0, 1'b0, 27);
    run_op(32'h3FC00000, 32'h3FC00000, 32'h3F800000, 1'b0, 1'b0, 27);
    run_op(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 2);
    run_op(32'h40000000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 2);
    run_op(32'h80000000, 32'h80000000, 32'h7F800000, 1'b1, 1'b0, 2);
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1, 27);
    run_op(32'h00800000, 32'h40800000, 32'h00000000, 1'b0, 1'b0, 27);
    run_op(32'hC0E00000, 32'hC0000000, 32'h40600000, 1'b0, 1'b0, 27);

    // A second start during DIV must be dropped: only one result is expected.
    sb_q.push_back('{res: 32'h40400000, dbz: 1'b0, ovf: 1'b0});
    @(negedge clk);
    op1 = 32'h40C00000; op2 = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h00000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("sb_drained_ignore", 64'(sb_q.size()), 64'd0);

    // Reset mid-DIV: nothing may complete and all outputs return to zero.
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_done", {63'd0, done}, 64'd0);
    check_eq("midrst_result", {32'd0, result}, 64'd0);
    check_eq("midrst_flags", {62'd0, dbz, ovf}, 64'd0);
    repeat (30) @(negedge clk);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 27);

    repeat (3) @(negedge clk);
    check_eq("sb_drained_end", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
